// File: rtl/align_array_ctrl_if.sv
// Bus bundle between the alignment sequencer, its sequence memories and the PE array.
interface align_array_ctrl_if #(
    parameter int unsigned N_PE   = 64,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned CALC_W = 16,
    parameter int unsigned BP_W   = 2
);
    localparam int unsigned SEL_W = (N_PE > 1) ? $clog2(N_PE) : 1;

    logic                     start;
    logic [ADDR_W-1:0]        query_len;
    logic [ADDR_W-1:0]        ref_len;
    logic [ADDR_W-1:0]        q_rd_addr;
    logic [BP_W-1:0]          q_rd_data;
    logic [ADDR_W-1:0]        r_rd_addr;
    logic [BP_W-1:0]          r_rd_data;
    logic [BP_W-1:0]          s_out;
    logic                     s_update;
    logic [BP_W-1:0]          t_out;
    logic                     valid_out;
    logic [ADDR_W-1:0]        col_out;
    logic [SEL_W-1:0]         max_sel;
    logic signed [CALC_W-1:0] max_in;
    logic [ADDR_W-1:0]        x_in;
    logic [ADDR_W-1:0]        y_in;
    logic                     busy;
    logic                     done;
    logic signed [CALC_W-1:0] best_score;
    logic [ADDR_W-1:0]        best_x;
    logic [ADDR_W-1:0]        best_y;

    // Sequencer side.
    modport master (
        input  start, query_len, ref_len, q_rd_data, r_rd_data, max_in, x_in, y_in,
        output q_rd_addr, r_rd_addr, s_out, s_update, t_out, valid_out, col_out,
        output max_sel, busy, done, best_score, best_x, best_y
    );

    // Memories, PE array and host side.
    modport slave (
        output start, query_len, ref_len, q_rd_data, r_rd_data, max_in, x_in, y_in,
        input  q_rd_addr, r_rd_addr, s_out, s_update, t_out, valid_out, col_out,
        input  max_sel, busy, done, best_score, best_x, best_y
    );
endinterface

// File: rtl/align_array_ctrl.sv
// Pass sequencer for the systolic affine-gap PE array: load query slice, stream reference,
// drain the wavefront, then fold the pass maximum into the global best.
module align_array_ctrl #(
    parameter int unsigned N_PE   = 64,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned CALC_W = 16,
    parameter int unsigned BP_W   = 2
) (
    input  logic               clk,
    input  logic               reset_i,
    align_array_ctrl_if.master bus
);
    localparam int unsigned SEL_W = (N_PE > 1) ? $clog2(N_PE) : 1;
    localparam int unsigned OFF_W = ADDR_W + 1;
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [OFF_W-1:0] NPE_O = OFF_W'(N_PE);
    localparam logic [CNT_W-1:0] NPE_C = CNT_W'(N_PE);

    typedef enum logic [2:0] {IDLE, LOAD, STREAM, DRAIN, ACCUM, DONE} state_t;

    state_t                   state;
    logic [ADDR_W-1:0]        qlen;
    logic [ADDR_W-1:0]        rlen;
    logic [OFF_W-1:0]         offset;
    logic [OFF_W-1:0]         rem;
    logic [CNT_W-1:0]         cnt;
    logic [OFF_W-1:0]         q_addr;
    logic [ADDR_W-1:0]        r_addr;
    logic                     s_upd;
    logic                     s_pad;
    logic                     v_out;
    logic [ADDR_W-1:0]        col;
    logic [SEL_W-1:0]         sel;
    logic                     busy_r;
    logic                     done_r;
    logic signed [CALC_W-1:0] best_s;
    logic [ADDR_W-1:0]        best_xr;
    logic [ADDR_W-1:0]        best_yr;

    logic [ADDR_W-1:0]        nxt_len;
    logic [OFF_W-1:0]         nxt_off;
    logic [OFF_W-1:0]         nxt_rem;

    // Query bases still covered by a pass starting at off, capped at the array size.
    function automatic logic [OFF_W-1:0] pass_rem(input logic [ADDR_W-1:0] len,
                                                  input logic [OFF_W-1:0]  off);
        logic [OFF_W-1:0] left;
        left = OFF_W'(len) - off;
        return (left > NPE_O) ? NPE_O : left;
    endfunction

    // Parameters of the pass about to be loaded (first pass from IDLE, next pass from ACCUM).
    always_comb begin
        nxt_len = (state == IDLE) ? bus.query_len : qlen;
        nxt_off = (state == IDLE) ? '0 : offset + NPE_O;
        nxt_rem = pass_rem(nxt_len, nxt_off);
    end

    // Sequencer FSM with registered strobes, addresses and result.
    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            state   <= IDLE;
            qlen    <= '0;
            rlen    <= '0;
            offset  <= '0;
            rem     <= '0;
            cnt     <= '0;
            q_addr  <= '0;
            r_addr  <= '0;
            s_upd   <= 1'b0;
            s_pad   <= 1'b0;
            v_out   <= 1'b0;
            col     <= '0;
            sel     <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            best_s  <= '0;
            best_xr <= '0;
            best_yr <= '0;
        end else begin
            s_upd  <= 1'b0;
            v_out  <= 1'b0;
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        qlen    <= bus.query_len;
                        rlen    <= bus.ref_len;
                        best_s  <= '0;
                        best_xr <= '0;
                        best_yr <= '0;
                        busy_r  <= 1'b1;
                        offset  <= '0;
                        if (bus.query_len != '0 && bus.ref_len != '0) begin
                            q_addr <= nxt_off + NPE_O - OFF_W'(1);
                            rem    <= nxt_rem;
                            sel    <= SEL_W'(nxt_rem - OFF_W'(1));
                            col    <= ADDR_W'(nxt_off);
                            cnt    <= '0;
                            state  <= LOAD;
                        end else begin
                            state  <= DONE;
                        end
                    end
                end
                LOAD: begin
                    // Data for the address shown this cycle arrives next cycle.
                    s_upd <= (cnt < NPE_C);
                    s_pad <= (q_addr >= OFF_W'(qlen));
                    if (cnt + CNT_W'(1) < NPE_C) begin
                        q_addr <= q_addr - OFF_W'(1);
                    end
                    if (cnt == NPE_C) begin
                        cnt    <= '0;
                        r_addr <= '0;
                        state  <= STREAM;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                STREAM: begin
                    v_out <= (cnt < CNT_W'(rlen));
                    if (cnt + CNT_W'(1) < CNT_W'(rlen)) begin
                        r_addr <= r_addr + ADDR_W'(1);
                    end
                    if (cnt == CNT_W'(rlen)) begin
                        cnt   <= '0;
                        state <= DRAIN;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DRAIN: begin
                    // Wavefront must reach PE[rem-1] and pass its output register.
                    if (cnt == CNT_W'(rem) + CNT_W'(1)) begin
                        cnt   <= '0;
                        state <= ACCUM;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ACCUM: begin
                    // Strict compare: ties keep the earlier pass.
                    if (bus.max_in > best_s) begin
                        best_s  <= bus.max_in;
                        best_xr <= bus.x_in;
                        best_yr <= bus.y_in;
                    end
                    offset <= nxt_off;
                    if (nxt_off < OFF_W'(qlen)) begin
                        q_addr <= nxt_off + NPE_O - OFF_W'(1);
                        rem    <= nxt_rem;
                        sel    <= SEL_W'(nxt_rem - OFF_W'(1));
                        col    <= ADDR_W'(nxt_off);
                        cnt    <= '0;
                        state  <= LOAD;
                    end else begin
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Base outputs pass the sync-read memory data straight through, qualified by the
    // registered strobe so they sit at zero whenever the strobe is low.
    assign bus.s_out      = (s_upd && !s_pad) ? bus.q_rd_data : '0;
    assign bus.t_out      = v_out ? bus.r_rd_data : '0;
    assign bus.s_update   = s_upd;
    assign bus.valid_out  = v_out;
    assign bus.q_rd_addr  = q_addr[ADDR_W-1:0];
    assign bus.r_rd_addr  = r_addr;
    assign bus.col_out    = col;
    assign bus.max_sel    = sel;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.best_score = best_s;
    assign bus.best_x     = best_xr;
    assign bus.best_y     = best_yr;
endmodule

// File: tb/tb_align_array_ctrl.sv
// Scoreboard bench for align_array_ctrl: expected bases, pass setup and results are queued
// at issue time and consumed by a monitor as the DUT presents them.
module tb_align_array_ctrl;
    localparam int unsigned N_PE   = 4;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned CALC_W = 16;
    localparam int unsigned BP_W   = 2;

    typedef struct { int score; int x; int y; int n_s; int n_v; int lat; } res_t;
    typedef struct { int col; int sel; } pass_t;

    logic clk = 1'b0;
    logic reset_i;
    always #5 clk = ~clk;

    align_array_ctrl_if #(.N_PE(N_PE), .ADDR_W(ADDR_W), .CALC_W(CALC_W), .BP_W(BP_W)) bus ();

    align_array_ctrl #(.N_PE(N_PE), .ADDR_W(ADDR_W), .CALC_W(CALC_W), .BP_W(BP_W)) dut (
        .clk    (clk),
        .reset_i(reset_i),
        .bus    (bus)
    );

    logic [BP_W-1:0] q_mem [256];
    logic [BP_W-1:0] r_mem [256];
    int pmax [256];
    int px   [256];
    int py   [256];

    res_t  exp_res [$];
    pass_t exp_pass[$];
    int    exp_s   [$];
    int    exp_t   [$];

    int n_pass = 0;
    int n_chk  = 0;
    int cyc    = 0;
    int start_cyc = 0;

    // Sync-read sequence memories.
    always @(posedge clk) begin
        bus.q_rd_data <= q_mem[bus.q_rd_addr];
        bus.r_rd_data <= r_mem[bus.r_rd_addr];
        cyc <= cyc + 1;
    end

    // Stand-in for the PE array's selected max/x/y, one entry per pass.
    assign bus.max_in = CALC_W'(pmax[bus.col_out / ADDR_W'(N_PE)]);
    assign bus.x_in   = ADDR_W'(px[bus.col_out / ADDR_W'(N_PE)]);
    assign bus.y_in   = ADDR_W'(py[bus.col_out / ADDR_W'(N_PE)]);

    task automatic check(input string nm, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    endtask

    // Monitor: consume queued expectations as strobes and done appear.
    int   m_s = 0, m_v = 0, m_ovl = 0;
    logic prev_v = 1'b0;
    always @(negedge clk) begin
        if (!reset_i) begin
            m_s = 0; m_v = 0; m_ovl = 0; prev_v = 1'b0;
        end else begin
            if (bus.s_update) begin
                m_s++;
                check("s_queued", int'(exp_s.size() != 0), 1);
                if (exp_s.size() != 0) check("s_out", int'(bus.s_out), exp_s.pop_front());
            end
            if (bus.valid_out) begin
                m_v++;
                if (!prev_v) begin
                    check("pass_queued", int'(exp_pass.size() != 0), 1);
                    if (exp_pass.size() != 0) begin
                        pass_t p;
                        p = exp_pass.pop_front();
                        check("col_out", int'(bus.col_out), p.col);
                        check("max_sel", int'(bus.max_sel), p.sel);
                    end
                end
                check("t_queued", int'(exp_t.size() != 0), 1);
                if (exp_t.size() != 0) check("t_out", int'(bus.t_out), exp_t.pop_front());
            end
            if (bus.s_update && bus.valid_out) m_ovl++;
            prev_v = bus.valid_out;
            if (bus.done) begin
                check("res_queued", int'(exp_res.size() != 0), 1);
                if (exp_res.size() != 0) begin
                    res_t r;
                    r = exp_res.pop_front();
                    check("best_score", int'(bus.best_score), r.score);
                    check("best_x", int'(bus.best_x), r.x);
                    check("best_y", int'(bus.best_y), r.y);
                    check("n_s_update", m_s, r.n_s);
                    check("n_valid", m_v, r.n_v);
                    check("strobe_overlap", m_ovl, 0);
                    check("busy_at_done", int'(bus.busy), 0);
                    if (r.lat >= 0) check("done_latency", cyc - start_cyc, r.lat);
                end
                m_s = 0; m_v = 0; m_ovl = 0;
            end
        end
    end

    task automatic set_pass(input int p, input int m, input int x, input int y);
        pmax[p] = m; px[p] = x; py[p] = y;
    endtask

    // Queue every expectation for one alignment, then pulse start.
    task automatic issue(input int ql, input int rl, input int lat);
        res_t r;
        int   p;
        r.score = 0; r.x = 0; r.y = 0; r.n_s = 0; r.n_v = 0; r.lat = lat;
        p = 0;
        for (int off = 0; ql > 0 && rl > 0 && off < ql; off += N_PE) begin
            int rem;
            pass_t ps;
            rem = (ql - off > N_PE) ? N_PE : ql - off;
            ps.col = off; ps.sel = rem - 1;
            exp_pass.push_back(ps);
            for (int i = N_PE - 1; i >= 0; i--)
                exp_s.push_back((off + i < ql) ? int'(q_mem[off + i]) : 0);
            for (int j = 0; j < rl; j++) exp_t.push_back(int'(r_mem[j]));
            if (pmax[p] > r.score) begin
                r.score = pmax[p]; r.x = px[p]; r.y = py[p];
            end
            r.n_s += N_PE;
            r.n_v += rl;
            p++;
        end
        exp_res.push_back(r);
        @(negedge clk);
        bus.query_len = ADDR_W'(ql);
        bus.ref_len   = ADDR_W'(rl);
        bus.start     = 1'b1;
        start_cyc     = cyc;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done();
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 400 && !seen; k++) begin
            @(negedge clk);
            seen = bus.done;
        end
        if (!seen) check("done_seen", int'(seen), 1);
    endtask

    task automatic wait_valid();
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            seen = bus.valid_out;
        end
        if (!seen) check("valid_seen", int'(seen), 1);
    endtask

    task automatic load_mem(input int qv[], input int rv[]);
        foreach (qv[i]) q_mem[i] = BP_W'(qv[i]);
        foreach (rv[i]) r_mem[i] = BP_W'(rv[i]);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            q_mem[i] = '0; r_mem[i] = '0; pmax[i] = 0; px[i] = 0; py[i] = 0;
        end
        reset_i       = 1'b0;
        bus.start     = 1'b0;
        bus.query_len = '0;
        bus.ref_len   = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_best", int'(bus.best_score), 0);
        check("rst_q_addr", int'(bus.q_rd_addr), 0);
        check("rst_r_addr", int'(bus.r_rd_addr), 0);
        check("rst_strobes", int'(bus.s_update) + int'(bus.valid_out), 0);
        reset_i = 1'b1;

        // Single pass, identical sequences, max 4*MATCH with MATCH=2.
        load_mem('{0, 1, 2, 3}, '{0, 1, 2, 3});
        set_pass(0, 8, 4, 4);
        issue(4, 4, -1);
        wait_done();

        // Three passes with a padded tail; pass 1 holds the best.
        load_mem('{1, 3, 0, 2, 2, 1, 3, 0, 1, 2}, '{2, 0, 1, 3, 1});
        set_pass(0, 5, 3, 2); set_pass(1, 9, 5, 4); set_pass(2, 3, 9, 1);
        issue(10, 5, -1);
        wait_done();

        // Zero lengths: immediate done, best cleared.
        issue(0, 5, 2);
        wait_done();
        issue(3, 0, 2);
        wait_done();

        // Tie keeps the first pass, strictly greater replaces it.
        load_mem('{3, 2, 1, 0, 0, 1, 2, 3}, '{1, 1, 2});
        set_pass(0, 7, 1, 2); set_pass(1, 7, 6, 3);
        issue(8, 3, -1);
        wait_done();
        set_pass(1, 8, 6, 3);
        issue(8, 3, -1);
        wait_done();

        // Start during STREAM must not disturb the running alignment.
        load_mem('{2, 2, 3, 1}, '{0, 3, 3, 1, 2, 0});
        set_pass(0, 6, 3, 5);
        issue(4, 6, -1);
        wait_valid();
        @(negedge clk);
        bus.query_len = ADDR_W'(1);
        bus.ref_len   = ADDR_W'(1);
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done();

        // Reset in the middle of STREAM drops strobes and busy at once.
        issue(4, 6, -1);
        wait_valid();
        @(negedge clk);
        reset_i = 1'b0;
        #1;
        check("midrst_busy", int'(bus.busy), 0);
        check("midrst_valid", int'(bus.valid_out), 0);
        exp_res.delete(); exp_pass.delete(); exp_s.delete(); exp_t.delete();
        repeat (2) @(negedge clk);
        reset_i = 1'b1;

        // Normal operation after the abort.
        load_mem('{0, 1, 2, 3}, '{0, 1, 2, 3});
        set_pass(0, 8, 4, 4);
        issue(4, 4, -1);
        wait_done();

        // All-mismatch: negative pass maxima never beat the cleared best.
        load_mem('{0, 0, 0, 0, 0, 0}, '{3, 3, 3, 3});
        set_pass(0, -3, 2, 2); set_pass(1, -1, 5, 3);
        issue(6, 4, -1);
        wait_done();

        repeat (3) @(negedge clk);
        check("queues_empty", exp_res.size() + exp_pass.size() + exp_s.size() + exp_t.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
